// File: rtl/platform_field.sv
// platform_field
//   Platform generator and renderer for the Doodle-Jump video path.
//   Keeps NUM_PLAT platform slots in registers. After reset each slot's X is
//   seeded from an internal LFSR. On every frame tick, when scrolling is
//   enabled, all slots move down by scroll_amt. Any slot that has left the
//   screen is then respawned at the top with a fresh random X. The block
//   also provides registered per-pixel and ball-landing hit results.
//
// Ports:
//   Clk, Reset          system clock; asynchronous active-high reset
//   frame_clk           vsync-rate tick, asynchronous to Clk
//   scroll_en           scroll during this frame
//   scroll_amt          pixels to scroll per frame (< SPACING)
//   DrawX, DrawY        current pixel  -> platform_on, plat_idx (1 Clk later)
//   BallX, BallY        ball centre    -> land_hit, land_y (1 Clk later)
//   Ball_size           ball half-size
//   busy                sequencer is not in IDLE
//   respawn_count       respawns since reset; wraps
//   frame_overrun       sticky; set when a frame tick had to be dropped
//
// State   | meaning
// INIT    | seed platX of one slot per Clk after reset
// IDLE    | wait for a frame tick (or a pended one)
// SCROLL  | add scroll_amt to every platY in one Clk
// RECYCLE | check one slot per Clk and respawn it if it is off screen

module platform_field #(
  parameter int          NUM_PLAT = 16,
  parameter int          SPACING  = 30,
  parameter int          HALF_W   = 4,
  parameter int          HALF_H   = 4,
  parameter int          SCREEN_H = 480,
  parameter int          X_MIN    = 16,
  parameter int          X_RANGE  = 608,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        scroll_en,
  input  logic [4:0]  scroll_amt,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  Ball_size,
  output logic        platform_on,
  output logic [4:0]  plat_idx,
  output logic        land_hit,
  output logic [9:0]  land_y,
  output logic        busy,
  output logic [15:0] respawn_count,
  output logic        frame_overrun
);

  localparam int SW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  // Geometry compares use 12 bits so that ball X plus size plus half-width
  // cannot wrap, even with extreme input values.
  localparam int GW = 12;

  localparam logic [15:0]   SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0]   LFSR_MASK = 16'hB400;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_PLAT - 1);
  localparam logic [9:0]    X_MIN_V   = 10'(X_MIN);
  localparam logic [9:0]    X_RANGE_V = 10'(X_RANGE);
  localparam logic [10:0]   RESPAWN_Y = 11'(SCREEN_H + HALF_H);
  localparam logic [10:0]   WRAP_Y    = 11'(NUM_PLAT * SPACING);
  localparam logic [10:0]   HALF_H_Y  = 11'(HALF_H);
  localparam logic [GW-1:0] HW_G      = GW'(HALF_W);
  localparam logic [GW-1:0] HH_G      = GW'(HALF_H);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_SCROLL,
    S_RECYCLE
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] slot;
  logic [15:0]   lfsr;
  logic [2:0]    fsync;
  logic          tick;
  logic          pending;

  logic [9:0]    plat_x [NUM_PLAT];
  logic [10:0]   plat_y [NUM_PLAT];

  logic          init_wr;
  logic          do_scroll;
  logic          recycle_chk;
  logic          start;
  logic          respawn_now;
  logic [9:0]    x_raw;
  logic [9:0]    x_off;
  logic [9:0]    new_x;

  logic          pix_hit_c;
  logic [4:0]    pix_idx_c;
  logic          land_hit_c;
  logic [9:0]    land_y_c;
  logic [GW-1:0] ball_bot;
  logic [GW-1:0] ball_l;
  logic [GW-1:0] ball_sz;

  // Galois LFSR, right shift; it steps every Clk regardless of state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

  // X_RANGE >= 512, so a single conditional subtract keeps r below X_RANGE.
  always_comb begin
    x_raw = lfsr[9:0];
    x_off = (x_raw >= X_RANGE_V) ? (x_raw - X_RANGE_V) : x_raw;
    new_x = X_MIN_V + x_off;
  end

  // Two-flop synchroniser, then a third flop for rising-edge detect.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsync <= 3'b000;
    end else begin
      fsync <= {fsync[1:0], frame_clk};
    end
  end

  assign tick = fsync[1] & ~fsync[2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    init_wr     = 1'b0;
    do_scroll   = 1'b0;
    recycle_chk = 1'b0;
    start       = 1'b0;
    case (state)
      S_INIT: begin
        init_wr = 1'b1;
        if (slot == LAST_SLOT) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (tick || pending) begin
          start = 1'b1;
          if (scroll_en) state_next = S_SCROLL;
        end
      end
      S_SCROLL: begin
        do_scroll  = 1'b1;
        state_next = S_RECYCLE;
      end
      S_RECYCLE: begin
        recycle_chk = 1'b1;
        if (slot == LAST_SLOT) state_next = S_IDLE;
      end
      default: state_next = S_INIT;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Slot counter, tick pending flag and sticky overrun flag. In IDLE a tick
  // starts the frame directly; while busy, one tick can be held as pending.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slot          <= '0;
      pending       <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      if (init_wr || recycle_chk) begin
        slot <= (slot == LAST_SLOT) ? '0 : slot + SW'(1);
      end else if (do_scroll) begin
        slot <= '0;
      end

      if (state == S_IDLE) begin
        if (start) pending <= 1'b0;
      end else if (tick) begin
        if (pending) frame_overrun <= 1'b1;
        else         pending       <= 1'b1;
      end
    end
  end

  assign respawn_now = (plat_y[slot] >= RESPAWN_Y);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        plat_x[i] <= '0;
        plat_y[i] <= 11'((i + 1) * SPACING);
      end
      respawn_count <= '0;
    end else begin
      if (init_wr) plat_x[slot] <= new_x;
      if (do_scroll) begin
        for (int i = 0; i < NUM_PLAT; i++) begin
          plat_y[i] <= plat_y[i] + {6'b000000, scroll_amt};
        end
      end
      if (recycle_chk && respawn_now) begin
        plat_y[slot]  <= plat_y[slot] - WRAP_Y;
        plat_x[slot]  <= new_x;
        respawn_count <= respawn_count + 16'd1;
      end
    end
  end

  // Pixel hit. The loop runs downward so that the lowest hit index wins.
  always_comb begin
    pix_hit_c = 1'b0;
    pix_idx_c = '0;
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      if (({2'b00, DrawX} + HW_G >= {2'b00, plat_x[i]}) &&
          ({2'b00, DrawX} <= {2'b00, plat_x[i]} + HW_G) &&
          ({2'b00, DrawY} + HH_G >= {1'b0, plat_y[i]}) &&
          ({2'b00, DrawY} <= {1'b0, plat_y[i]} + HH_G)) begin
        pix_hit_c = 1'b1;
        pix_idx_c = 5'(i);
      end
    end
  end

  // Landing hit. The ball bottom edge must lie within the platform's
  // vertical span, and the two X spans must overlap.
  always_comb begin
    ball_sz    = {2'b00, Ball_size};
    ball_l     = {2'b00, BallX};
    ball_bot   = {2'b00, BallY} + ball_sz;
    land_hit_c = 1'b0;
    land_y_c   = '0;
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      if ((ball_bot + HH_G >= {1'b0, plat_y[i]}) &&
          (ball_bot <= {1'b0, plat_y[i]} + HH_G) &&
          (ball_l + ball_sz + HW_G >= {2'b00, plat_x[i]}) &&
          (ball_l <= {2'b00, plat_x[i]} + HW_G + ball_sz)) begin
        land_hit_c = 1'b1;
        land_y_c   = 10'(plat_y[i] - HALF_H_Y);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      platform_on <= 1'b0;
      plat_idx    <= '0;
      land_hit    <= 1'b0;
      land_y      <= '0;
    end else begin
      platform_on <= pix_hit_c;
      plat_idx    <= pix_idx_c;
      land_hit    <= land_hit_c;
      land_y      <= land_y_c;
    end
  end

endmodule
